// File: rtl/tone_divider_pkg.sv
// Shared tone constants for the music player; the note decoder uses the same values.
// Preloads are 13-bit counts against a 4 MHz base tick; the all-ones preload means rest.
package tone_divider_pkg;

    localparam int unsigned TONE_W       = 13;
    localparam logic [TONE_W-1:0] TONE_REST = {TONE_W{1'b1}};
    localparam int unsigned TONE_BASE_HZ = 4_000_000;

    // RESTING is the reset state; the Resting output is this encoding directly.
    typedef enum logic {
        ST_RUNNING = 1'b0,
        ST_RESTING = 1'b1
    } tone_state_e;

endpackage

// File: rtl/tone_divider_if.sv
// Note-decoder to speaker-driver bundle: count-enable tick and preload in, speaker drive and status out.
// No flow control: ToneIn is sampled only at half-period boundaries or while resting.
interface tone_divider_if
    import tone_divider_pkg::*;
#(
    parameter int unsigned WIDTH = TONE_W
);
    logic             ClkEn;
    logic [WIDTH-1:0] ToneIn;
    logic             SpkOut;
    logic             PeriodTick;
    logic             Resting;
    logic [WIDTH-1:0] CurTone;

    modport master (
        output ClkEn,
        output ToneIn,
        input  SpkOut,
        input  PeriodTick,
        input  Resting,
        input  CurTone
    );

    modport slave (
        input  ClkEn,
        input  ToneIn,
        output SpkOut,
        output PeriodTick,
        output Resting,
        output CurTone
    );
endinterface

// File: rtl/tone_divider_counter.sv
// Loadable up-counter with an at-top flag; load wins over increment.
// One-cycle latency from load/inc to cnt; the caller never increments past all-ones.
module tone_divider_counter
    import tone_divider_pkg::*;
#(
    parameter int unsigned WIDTH = TONE_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt,
    output logic             at_top
);
    logic [WIDTH-1:0] cnt_d;
    logic [WIDTH-1:0] cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (inc) begin
            cnt_d = cnt_q + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt    = cnt_q;
    assign at_top = (cnt_q == {WIDTH{1'b1}});
endmodule

// File: rtl/tone_divider.sv
// Programmable divider and speaker driver: SpkOut toggles every (2**WIDTH - CurTone) ClkEn ticks.
// All outputs registered; PeriodTick lands one Clk after the boundary tick, no path from ToneIn to SpkOut.
module tone_divider
    import tone_divider_pkg::*;
#(
    parameter int unsigned WIDTH = TONE_W
) (
    input  logic          Clk,
    input  logic          Rst,
    tone_divider_if.slave tif
);
    localparam logic [WIDTH-1:0] REST = {WIDTH{1'b1}};

    tone_state_e      state_d;
    tone_state_e      state_q;
    logic             spk_d;
    logic             spk_q;
    logic             tick_d;
    logic             tick_q;
    logic [WIDTH-1:0] cur_tone_d;
    logic [WIDTH-1:0] cur_tone_q;

    logic             cnt_load;
    logic             cnt_inc;
    logic [WIDTH-1:0] cnt;
    logic             cnt_at_top;
    logic             tone_is_rest;

    assign tone_is_rest = (tif.ToneIn == REST);

    tone_divider_counter #(
        .WIDTH (WIDTH)
    ) u_counter (
        .clk      (Clk),
        .rst      (Rst),
        .load     (cnt_load),
        .load_val (tif.ToneIn),
        .inc      (cnt_inc),
        .cnt      (cnt),
        .at_top   (cnt_at_top)
    );

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= ST_RESTING;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (tif.ClkEn) begin
            case (state_q)
                ST_RESTING: if (!tone_is_rest)               state_d = ST_RUNNING;
                ST_RUNNING: if (cnt_at_top && tone_is_rest)  state_d = ST_RESTING;
                default:                                     state_d = ST_RESTING;
            endcase
        end
    end

    // ToneIn is only looked at on a load, so mid-half-period changes wait for the boundary.
    always_comb begin
        spk_d      = spk_q;
        tick_d     = 1'b0;
        cur_tone_d = cur_tone_q;
        cnt_load   = 1'b0;
        cnt_inc    = 1'b0;
        if (tif.ClkEn) begin
            case (state_q)
                ST_RESTING: begin
                    spk_d = 1'b0;
                    if (!tone_is_rest) begin
                        cur_tone_d = tif.ToneIn;
                        cnt_load   = 1'b1;
                    end
                end
                ST_RUNNING: begin
                    if (cnt_at_top) begin
                        tick_d     = 1'b1;
                        cur_tone_d = tif.ToneIn;
                        cnt_load   = 1'b1;
                        spk_d      = tone_is_rest ? 1'b0 : ~spk_q;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
                default: begin
                    spk_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            spk_q      <= 1'b0;
            tick_q     <= 1'b0;
            cur_tone_q <= REST;
        end else begin
            spk_q      <= spk_d;
            tick_q     <= tick_d;
            cur_tone_q <= cur_tone_d;
        end
    end

    assign tif.SpkOut     = spk_q;
    assign tif.PeriodTick = tick_q;
    assign tif.Resting    = (state_q == ST_RESTING);
    assign tif.CurTone    = cur_tone_q;
endmodule
